// File: rtl/regdump_pkg.sv
// Shared constants and FSM state encodings for the register-file dump reader.
package regdump_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTES_PER_WORD * 8;
  localparam int REG_IDX_W      = 5;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_HDR   = 3'd1;
  localparam state_t ST_FETCH = 3'd2;
  localparam state_t ST_SEND  = 3'd3;
  localparam state_t ST_CKSUM = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready byte stream carrying the register dump to a UART or debug sink.
interface regfile_dump_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/regdump_byte_shifter.sv
// Holds one captured register word and shifts it out a byte at a time, LSB first.
module regdump_byte_shifter
  import regdump_pkg::*;
(
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              load,
  input  logic [WORD_W-1:0] loadData,
  input  logic              shift,
  output logic [7:0]        lowByte,
  output logic              lastByte
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [WORD_W-1:0] shiftReg;
  logic [CNT_W-1:0]  byteCntReg;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      shiftReg   <= '0;
      byteCntReg <= '0;
    end else if (load) begin
      shiftReg   <= loadData;
      byteCntReg <= '0;
    end else if (shift) begin
      shiftReg   <= {8'h00, shiftReg[WORD_W-1:8]};
      byteCntReg <= byteCntReg + 1'b1;
    end
  end

  assign lowByte  = shiftReg[7:0];
  assign lastByte = (byteCntReg == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/regfile_dump.sv
// Walks FIRST_REG..LAST_REG over a spare regfile read port and streams each word as 4 bytes.
// Optional trailing checksum byte: define REGDUMP_CHECKSUM_EN.
module regfile_dump
  import regdump_pkg::*;
#(
  parameter int         FIRST_REG   = 0,
  parameter int         LAST_REG    = 31,
  parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER
) (
  input  logic                 clock,
  input  logic                 ctrl_reset_n,
  input  logic                 start,
  output logic [REG_IDX_W-1:0] ctrl_readReg,
  input  logic [WORD_W-1:0]    data_readReg,
  regfile_dump_if.master       tx,
  output logic                 busy,
  output logic                 done
);

`ifdef REGDUMP_CHECKSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CKSUM;
`else
  localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

  state_t               stateReg, stateNext;
  logic [REG_IDX_W-1:0] idxReg;
  logic                 handshake, loadWord, shiftByte, lastByte, atLastReg, wordDone;
  logic [7:0]           lowByte;
  logic [7:0]           txData;

  assign handshake = tx.tx_valid && tx.tx_ready;
  assign loadWord  = (stateReg == ST_FETCH);
  assign shiftByte = (stateReg == ST_SEND) && handshake;
  assign wordDone  = shiftByte && lastByte;
  assign atLastReg = (idxReg == REG_IDX_W'(LAST_REG));

  regdump_byte_shifter shifter (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .load         (loadWord),
    .loadData     (data_readReg),
    .shift        (shiftByte),
    .lowByte      (lowByte),
    .lastByte     (lastByte)
  );

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_IDLE:  if (start) stateNext = ST_HDR;
      ST_HDR:   if (handshake) stateNext = ST_FETCH;
      ST_FETCH: stateNext = ST_SEND;
      ST_SEND:  if (wordDone) stateNext = atLastReg ? ST_AFTER_DATA : ST_FETCH;
`ifdef REGDUMP_CHECKSUM_EN
      ST_CKSUM: if (handshake) stateNext = ST_DONE;
`endif
      ST_DONE:  stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      stateReg <= ST_IDLE;
      idxReg   <= REG_IDX_W'(FIRST_REG);
    end else begin
      stateReg <= stateNext;
      if (stateReg == ST_IDLE && start)
        idxReg <= REG_IDX_W'(FIRST_REG);
      else if (wordDone && !atLastReg)
        idxReg <= idxReg + 1'b1;
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0] sumReg;

  // Running sum of payload bytes only; the header is not part of the checksum.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n)
      sumReg <= 8'h00;
    else if (stateReg == ST_IDLE)
      sumReg <= 8'h00;
    else if (shiftByte)
      sumReg <= sumReg + lowByte;
  end
`endif

  // Output byte is a function of registered state only, so it holds while stalled.
  always_comb begin
    txData = 8'h00;
    case (stateReg)
      ST_HDR:   txData = HEADER_BYTE;
      ST_SEND:  txData = lowByte;
`ifdef REGDUMP_CHECKSUM_EN
      ST_CKSUM: txData = 8'h00 - sumReg;
`endif
      default:  txData = 8'h00;
    endcase
  end

  assign tx.tx_data  = txData;
  assign tx.tx_valid = (stateReg == ST_HDR) || (stateReg == ST_SEND)
`ifdef REGDUMP_CHECKSUM_EN
                       || (stateReg == ST_CKSUM)
`endif
                       ;
  assign ctrl_readReg = idxReg;
  assign busy         = (stateReg != ST_IDLE);
  assign done         = (stateReg == ST_DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: full 0..31 dump instance plus a single-register instance.
module tb_regfile_dump;
  import regdump_pkg::*;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int FRAME_LAT  = 163;
  localparam int SINGLE_LAT = 8;
`else
  localparam int FRAME_LAT  = 162;
  localparam int SINGLE_LAT = 7;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        ctrl_reset_n, start, start1;
  logic [4:0]  ctrl_readReg, ctrl_readReg1;
  logic [31:0] data_readReg, data_readReg1;
  logic        busy, done, busy1, done1;
  logic [31:0] regs [32];

  regfile_dump_if txIf ();
  regfile_dump_if txIf1 ();

  regfile_dump dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n), .start(start),
    .ctrl_readReg(ctrl_readReg), .data_readReg(data_readReg),
    .tx(txIf.master), .busy(busy), .done(done)
  );

  regfile_dump #(.FIRST_REG(1), .LAST_REG(1)) dutOne (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n), .start(start1),
    .ctrl_readReg(ctrl_readReg1), .data_readReg(data_readReg1),
    .tx(txIf1.master), .busy(busy1), .done(done1)
  );

  assign data_readReg  = (ctrl_readReg  == 5'd0) ? 32'h0 : regs[ctrl_readReg];
  assign data_readReg1 = (ctrl_readReg1 == 5'd0) ? 32'h0 : regs[ctrl_readReg1];

  int nCompared = 0;
  int nMismatch = 0;
  int cyc = 0;
  int startCyc = 0;
  int acceptedCnt = 0;
  int donePulses = 0;
  int readyMode = 1;  // 0 hold low, 1 hold high, 2 random
  bit monEn = 1'b1;
  bit stallPending = 1'b0;
  logic [7:0] stallData;
  logic [7:0] expQ[$];
  logic [7:0] expQ1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(posedge clock);
    #1;
    case (readyMode)
      0:       txIf.tx_ready = 1'b0;
      1:       txIf.tx_ready = 1'b1;
      default: txIf.tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial txIf1.tx_ready = 1'b1;

  // Monitor for the full-range instance: byte scoreboard, stall stability, done pulses.
  initial forever begin
    @(negedge clock);
    if (done) donePulses++;
    if (monEn) begin
      if (stallPending) begin
        check("stall valid held", txIf.tx_valid, 1'b1);
        check("stall data held", txIf.tx_data, stallData);
      end
      if (txIf.tx_valid && txIf.tx_ready) begin
        acceptedCnt++;
        if (expQ.size() == 0) check("unexpected byte", txIf.tx_data, 32'hFFFF_FFFF);
        else check($sformatf("byte %0d", acceptedCnt), txIf.tx_data, expQ.pop_front());
      end
      stallPending = txIf.tx_valid && !txIf.tx_ready;
      stallData    = txIf.tx_data;
    end
  end

  initial forever begin
    @(negedge clock);
    if (txIf1.tx_valid && txIf1.tx_ready) begin
      if (expQ1.size() == 0) check("single unexpected byte", txIf1.tx_data, 32'hFFFF_FFFF);
      else check("single byte", txIf1.tx_data, expQ1.pop_front());
    end
  end

  task automatic pushFrame();
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [31:0] w;
    sum = 8'h00;
    expQ.push_back(8'hA5);
    for (int r = 0; r < 32; r++) begin
      w = (r == 0) ? 32'h0 : regs[r];
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        expQ.push_back(b);
        sum = sum + b;
      end
    end
`ifdef REGDUMP_CHECKSUM_EN
    expQ.push_back(8'h00 - sum);
`endif
  endtask

  task automatic pulseStart();
    @(posedge clock); #1;
    start = 1'b1;
    startCyc = cyc;
    check("busy low before start", busy, 1'b0);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Runs one dump; optionally re-pulses start at rePulseReg or rewrites r2 right after its FETCH.
  task automatic runFrame(input string tag, input bit checkLat, input int rePulseReg, input bit writeR2);
    int  d0;
    int  lat;
    bit  seen;
    bit  busyDrop;
    bit  pulsed;
    bit  wrote;
    d0 = donePulses; lat = 0; seen = 0; busyDrop = 0; pulsed = 0; wrote = 0;
    pulseStart();
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clock);
      if (i == 0) begin
        check({tag, " header valid"}, txIf.tx_valid, 1'b1);
        check({tag, " busy after start"}, busy, 1'b1);
      end
      if (!busy) busyDrop = 1'b1;
      if (done) begin
        seen = 1'b1;
        lat  = cyc - startCyc;
      end
      if (start) start = 1'b0;
      if (rePulseReg >= 0 && !pulsed && ctrl_readReg == 5'(rePulseReg)) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (writeR2 && !wrote && ctrl_readReg == 5'd2) begin
        @(posedge clock); #1;
        regs[2] = 32'hCAFE_F00D;
        wrote = 1'b1;
      end
    end
    start = 1'b0;
    check({tag, " done seen"}, seen, 1'b1);
    check({tag, " busy held"}, busyDrop, 1'b0);
    if (checkLat) check({tag, " done latency"}, lat, FRAME_LAT);
    repeat (30) @(negedge clock);
    check({tag, " bytes left"}, expQ.size(), 0);
    check({tag, " done pulses"}, donePulses - d0, 1);
  endtask

  initial begin
    int base;
    int lat;
    bit seen;
    bit hit;
    ctrl_reset_n = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    for (int r = 0; r < 32; r++) regs[r] = 32'h0;
    regs[1]  = 32'h1122_3344;
    regs[31] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clock);
    check("reset tx_valid", txIf.tx_valid, 1'b0);
    check("reset tx_data", txIf.tx_data, 8'h00);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset readReg", ctrl_readReg, 5'd0);
    check("reset readReg single", ctrl_readReg1, 5'd1);
    @(posedge clock); #3;
    ctrl_reset_n = 1'b1;

    // Hand-checked frame head: A5, r0 = 00 00 00 00, r1 = 44 33 22 11.
    check("frame head", {regs[1][7:0], regs[1][15:8], regs[1][23:16], regs[1][31:24]}, 32'h4433_2211);
    pushFrame();
    runFrame("ready1", 1'b1, -1, 1'b0);

    readyMode = 2;
    pushFrame();
    runFrame("random", 1'b0, -1, 1'b0);
    readyMode = 1;

    pushFrame();
    runFrame("restart", 1'b1, 5, 1'b0);

    pushFrame();
    runFrame("write old", 1'b1, -1, 1'b1);
    check("r2 written", regs[2], 32'hCAFE_F00D);
    pushFrame();
    runFrame("write new", 1'b1, -1, 1'b0);

    // Reset while the 2nd byte of r10 (frame byte index 42) is stalled.
    pushFrame();
    base = acceptedCnt;
    pulseStart();
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(posedge clock); #2;
      if (acceptedCnt - base == 42) begin
        readyMode = 0;
        txIf.tx_ready = 1'b0;
        hit = 1'b1;
      end
    end
    check("reached r10 byte 2", hit, 1'b1);
    @(negedge clock);
    check("r10 stalled valid", txIf.tx_valid, 1'b1);
    check("r10 stalled readReg", ctrl_readReg, 5'd10);
    #2;
    monEn = 1'b0;
    ctrl_reset_n = 1'b0;
    #1;
    check("async reset tx_valid", txIf.tx_valid, 1'b0);
    check("async reset busy", busy, 1'b0);
    check("async reset readReg", ctrl_readReg, 5'd0);
    expQ.delete();
    stallPending = 1'b0;
    @(posedge clock); #3;
    ctrl_reset_n = 1'b1;
    readyMode = 1;
    monEn = 1'b1;
    pushFrame();
    runFrame("after reset", 1'b1, -1, 1'b0);

    // Single-register instance: r1 = 01020304 gives A5 04 03 02 01 (then F6 with checksum).
    regs[1] = 32'h0102_0304;
    expQ1.push_back(8'hA5);
    expQ1.push_back(8'h04);
    expQ1.push_back(8'h03);
    expQ1.push_back(8'h02);
    expQ1.push_back(8'h01);
`ifdef REGDUMP_CHECKSUM_EN
    expQ1.push_back(8'hF6);
`endif
    @(posedge clock); #1;
    start1 = 1'b1;
    base = cyc;
    @(posedge clock); #1;
    start1 = 1'b0;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (done1) begin
        seen = 1'b1;
        lat = cyc - base;
      end
    end
    check("single done seen", seen, 1'b1);
    check("single done latency", lat, SINGLE_LAT);
    check("single bytes left", expQ1.size(), 0);
    repeat (5) @(negedge clock);
    check("single idle after", busy1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
